// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory access controller.
// Size encodings, FSM states and the default memory size.
package dm_pkg;

    localparam int DM_MEM_BYTES = 128;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RD_WAIT,
        ST_WR,
        ST_RESP
    } dm_state_e;

endpackage

// File: rtl/dm_byte_lane.sv
// Big-endian lane extract/merge for one 32-bit memory word.
// Byte offset o lives in bits [31-8o -: 8]; halfword offset 2 is [15:0].
module dm_byte_lane
    import dm_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [4:0]  w_bshift;
    logic [4:0]  w_hshift;
    logic [31:0] w_bword;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // (3 - offset) * 8: distance of the byte lane from bit 0
    assign w_bshift = {~i_offset, 3'b000};
    assign w_hshift = i_offset[1] ? 5'd0 : 5'd16;
    assign w_bword  = i_word >> w_bshift;
    assign w_byte   = w_bword[7:0];
    assign w_half   = i_offset[1] ? i_word[15:0] : i_word[31:16];

    // Extend the selected lane for loads; splice store data into the word
    always_comb begin
        o_load   = i_word;
        o_merged = i_wdata;
        unique case (i_size)
            SZ_BYTE: begin
                o_load   = {{24{i_signed & w_byte[7]}}, w_byte};
                o_merged = (i_word & ~(32'h0000_00FF << w_bshift))
                         | ({24'd0, i_wdata[7:0]} << w_bshift);
            end
            SZ_HALF: begin
                o_load   = {{16{i_signed & w_half[15]}}, w_half};
                o_merged = (i_word & ~(32'h0000_FFFF << w_hshift))
                         | ({16'd0, i_wdata[15:0]} << w_hshift);
            end
            default: begin
                o_load   = i_word;
                o_merged = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// Load/store controller driving a word-wide big-endian data memory.
// Sub-word stores are done as read-modify-write; all outputs registered.
module dm_access_ctrl
    import dm_pkg::*;
#(
    parameter int MEM_BYTES = DM_MEM_BYTES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] Address,
    output logic [31:0] data,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] DM_data
);

    localparam logic [31:0] LP_MAX_WORD = 32'(MEM_BYTES - 4);

    dm_state_e   r_state;
    dm_state_e   w_state_nxt;
    logic        r_write;
    logic        r_signed;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic [31:0] r_wdata;
    logic [31:0] w_waddr;
    logic        w_accept;
    logic        w_req_err;
    logic [31:0] w_lane_load;
    logic [31:0] w_lane_merge;
    logic [31:0] w_addr_nxt;
    logic [31:0] w_data_nxt;
    logic [31:0] w_rdata_nxt;
    logic        w_err_nxt;

    assign w_waddr  = {req_addr[31:2], 2'b00};
    assign w_accept = req_valid & req_ready;

    assign w_req_err = (req_size == 2'd3)
                     | ((req_size == SZ_HALF) & req_addr[0])
                     | ((req_size == SZ_WORD) & (|req_addr[1:0]))
                     | (w_waddr > LP_MAX_WORD);

    dm_byte_lane u_lane (
        .i_word   (DM_data),
        .i_offset (r_off),
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_wdata  (r_wdata),
        .o_load   (w_lane_load),
        .o_merged (w_lane_merge)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state plus next values of the held output registers
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = Address;
        w_data_nxt  = data;
        w_rdata_nxt = resp_rdata;
        w_err_nxt   = resp_err;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_rdata_nxt = '0;
                    w_err_nxt   = w_req_err;
                    if (w_req_err) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_addr_nxt = w_waddr;
                        if (req_write && req_size == SZ_WORD) begin
                            w_state_nxt = ST_WR;
                            w_data_nxt  = req_wdata;
                        end else begin
                            w_state_nxt = ST_RD;
                        end
                    end
                end
            end
            ST_RD: w_state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: begin
                // DM_data is valid this whole cycle
                if (r_write) begin
                    w_state_nxt = ST_WR;
                    w_data_nxt  = w_lane_merge;
                end else begin
                    w_state_nxt = ST_RESP;
                    w_rdata_nxt = w_lane_load;
                end
            end
            ST_WR:   w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Latch request fields at acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write  <= 1'b0;
            r_signed <= 1'b0;
            r_size   <= SZ_BYTE;
            r_off    <= 2'd0;
            r_wdata  <= '0;
        end else if (w_accept) begin
            r_write  <= req_write;
            r_signed <= req_signed;
            r_size   <= req_size;
            r_off    <= req_addr[1:0];
            r_wdata  <= req_wdata;
        end
    end

    // Registered outputs, decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            Address    <= '0;
            data       <= '0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
        end else begin
            req_ready  <= (w_state_nxt == ST_IDLE);
            resp_valid <= (w_state_nxt == ST_RESP);
            MemRead    <= (w_state_nxt == ST_RD);
            MemWrite   <= (w_state_nxt == ST_WR);
            resp_err   <= w_err_nxt;
            resp_rdata <= w_rdata_nxt;
            Address    <= w_addr_nxt;
            data       <= w_data_nxt;
        end
    end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Initiator-side load/store controller for the word-wide data memory.
- Accepts one byte, halfword or word request at a time from the CPU MEM stage and turns it into MemRead/MemWrite/Address/data cycles on the memory.
- Sub-word stores become a read-modify-write, because the memory only moves whole 32-bit big-endian words.
- Returns load data with sign or zero extension, plus an error flag for misaligned or out-of-range accesses.

Parameters:
- MEM_BYTES, 128: memory size in bytes. Legal word addresses are 0 to MEM_BYTES-4.

Ports:
- clk  in  1  clock; every state change on the rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller idle and able to accept
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is illegal
- req_signed  in  1  sign-extend load result (byte/halfword only)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned for sub-word stores
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualifies resp_valid: misaligned, out of range, or size 3
- Address  out  32  word-aligned memory address; addr[1:0] always 00
- data  out  32  memory write data
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- DM_data  in  32  memory read data, registered inside the memory on posedge when MemRead=1

Behaviour:
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; Address=0; data=0; MemRead=0; MemWrite=0. All outputs are registered.
- Memory timing contract:
  - The memory samples MemRead on posedge, so DM_data is valid for the whole following cycle.
  - The memory commits writes on the negedge of any cycle with MemWrite=1.
- FSM states: IDLE, RD, RD_WAIT, WR, RESP.
- Handshake: a request is accepted on a posedge with req_valid=1 and req_ready=1. req_ready=1 only in IDLE. All request fields are latched at acceptance.
- Error check at acceptance (err if any):
  - size==3
  - halfword with addr[0]=1
  - word with addr[1:0]!=0
  - (addr & ~3) > MEM_BYTES-4
  - Error path: IDLE -> RESP with resp_err=1. No MemRead or MemWrite is ever asserted.
- Load path: IDLE -> RD (MemRead=1, Address=addr&~3) -> RD_WAIT (MemRead=0; DM_data sampled at end of cycle) -> RESP.
- Word store path: IDLE -> WR (MemWrite=1, data=req_wdata) -> RESP.
- Sub-word store path: IDLE -> RD -> RD_WAIT -> WR (data = DM_data with the target lane replaced) -> RESP.
- Latency from the accept edge to the resp_valid cycle:
  - error: 1 cycle
  - word store: 2 cycles
  - load: 3 cycles
  - sub-word store: 4 cycles
- Big-endian lane mapping:
  - byte offset o occupies bits [31-8o -: 8]
  - halfword offset 0 -> [31:16]; offset 2 -> [15:0]
- Loads: the lane is extracted, right-aligned, then sign-extended if req_signed, else zero-extended. Word loads ignore req_signed.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - req_ready becomes 1 the cycle after RESP, so back-to-back requests are spaced by at least one idle cycle.
- MemRead and MemWrite are never high in the same cycle. Each is high for exactly one cycle per access.
- Address and data hold their last values outside active cycles.
- Reset mid-operation:
  - rst sampled high forces IDLE and clears the strobes at that posedge. No resp_valid is produced for the aborted request.
  - A WR cycle in which rst rises still performs its negedge write, since MemWrite is already registered high.
- req_valid while not ready: ignored. The requester must hold the request.

Decomposition:
- Shared package dm_pkg:
  - size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2
  - FSM state enum
  - MEM_BYTES default constant
- One combinational sub-module, dm_byte_lane, is natural:
  - inputs: word, offset, size, signed flag, store data
  - outputs: extended load value and merged store word

Test Plan:
- Word store addr=0x08, wdata=0xDEADBEEF, then word load addr=0x08 -> MemWrite pulses 1 cycle with Address=0x08, data=0xDEADBEEF; load resp_rdata=0xDEADBEEF 3 cycles after accept, resp_err=0.
- After the above: signed byte load addr=0x09 -> 0xFFFFFFAD; unsigned halfword load addr=0x0A -> 0x0000BEEF.
- Byte store addr=0x0B, wdata=0x11 -> MemRead cycle then MemWrite cycle with data=0xDEADBE11; the following word load returns 0xDEADBE11; resp 4 cycles after accept.
- Word load addr=0x06, halfword load addr=0x03, word load addr=0x80, size=3 -> each gives resp_err=1 one cycle after accept, MemRead/MemWrite never asserted.
- rst asserted during RD_WAIT of a load -> next cycle IDLE, req_ready=1, no resp_valid; a following word load of 0x08 completes normally.
- req_valid held high for 3 consecutive loads -> accepts spaced by 4 cycles, exactly one resp_valid per request, in order.
